board_game_engine: RTL and testbench

Parametrised turn-based N×N board engine for two players (X, O), generalising the 3×3 tic-tac-toe controller. Takes decoded cell clicks from the mouse/click-decode path, keeps X and O occupancy matrices, detects K-in-a-row wins (rows, columns, both diagonals), tracks turn and saturating scores, and drives screen-select flags to the VGA painter. Sits between clicked-cell decode / debouncers and the VGA painter; replaces separate FSM and score-counter blocks.

---
 rtl/board_game_engine.sv | 240 ++++++++++++++++++++++++
 tb/tb_board_game_engine.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_game_engine.sv
`default_nettype none
// +-------------------------------------------------------------------------------------+
// | board_game_engine : N x N two-player engine with K-in-a-row win detection, saturating |
// | scores and one-hot screen select. Define UNDO_EN to enable single-level undo. Rev 1.0 |
// +-------------------------------------------------------------------------------------+
module board_game_engine #(
    parameter int  N       = 3,
    parameter int  K       = 3,
    parameter int  SCORE_W = 6,
    localparam int IDX_W   = $clog2(N*N)
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               click_valid,
    input  logic [IDX_W-1:0]   click_idx,
    input  logic               any_click,
    input  logic               erase,
    input  logic               restart,
    output logic [N*N-1:0]     x_matrix,
    output logic [N*N-1:0]     o_matrix,
    output logic               turn_x,
    output logic [SCORE_W-1:0] score_x,
    output logic [SCORE_W-1:0] score_o,
    output logic               inc_x_score,
    output logic               inc_o_score,
    output logic               disp_start,
    output logic               disp_play,
    output logic               disp_win_x,
    output logic               disp_win_o,
    output logic               disp_tie
);

    localparam int                 CELLS       = N*N;
    localparam logic [CELLS-1:0]   c_ONE       = {{(CELLS-1){1'b0}}, 1'b1};
    localparam logic [SCORE_W-1:0] c_SCORE_ONE = {{(SCORE_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_PLAY  = 3'd1,
        S_CHECK = 3'd2,
        S_WIN_X = 3'd3,
        S_WIN_O = 3'd4,
        S_TIE   = 3'd5
    } state_t;

    state_t             r_state, w_next;
    logic [4:0]         r_disp;
    logic [CELLS-1:0]   r_x, r_o;
    logic               r_turn_x;
    logic [SCORE_W-1:0] r_score_x, r_score_o;
    logic               r_inc_x, r_inc_o;
    logic               r_any_d, r_restart_d;

    logic               w_any_rise, w_restart_rise, w_clear, w_place, w_undo_fire;
    logic               w_win, w_full, w_click_ok;
    logic [CELLS-1:0]   w_occ, w_click_bit, w_mover;
    logic [4*CELLS-1:0] w_hits;

    function automatic logic [CELLS-1:0] f_mask(input int r, input int c, input int dr, input int dc);
        logic [CELLS-1:0] m;
        m = '0;
        for (int k = 0; k < K; k++)
            m = m | (c_ONE << ((r + k*dr)*N + c + k*dc));
        return m;
    endfunction

    function automatic logic [4:0] f_disp(input state_t s);
        case (s)
            S_START:         f_disp = 5'b10000;
            S_PLAY, S_CHECK: f_disp = 5'b01000;
            S_WIN_X:         f_disp = 5'b00100;
            S_WIN_O:         f_disp = 5'b00010;
            S_TIE:           f_disp = 5'b00001;
            default:         f_disp = 5'b10000;
        endcase
    endfunction

    // Only windows lying wholly on the board are built, so runs never wrap between rows.
    assign w_mover = r_turn_x ? r_x : r_o;
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            localparam int c_BASE = 4*(r*N + c);
            if (c + K <= N) begin : g_h
                localparam logic [CELLS-1:0] c_M = f_mask(r, c, 0, 1);
                assign w_hits[c_BASE] = (w_mover & c_M) == c_M;
            end else begin : g_h_none
                assign w_hits[c_BASE] = 1'b0;
            end
            if (r + K <= N) begin : g_v
                localparam logic [CELLS-1:0] c_M = f_mask(r, c, 1, 0);
                assign w_hits[c_BASE+1] = (w_mover & c_M) == c_M;
            end else begin : g_v_none
                assign w_hits[c_BASE+1] = 1'b0;
            end
            if ((r + K <= N) && (c + K <= N)) begin : g_d
                localparam logic [CELLS-1:0] c_M = f_mask(r, c, 1, 1);
                assign w_hits[c_BASE+2] = (w_mover & c_M) == c_M;
            end else begin : g_d_none
                assign w_hits[c_BASE+2] = 1'b0;
            end
            if ((r + K <= N) && (c + 1 >= K)) begin : g_a
                localparam logic [CELLS-1:0] c_M = f_mask(r, c, 1, -1);
                assign w_hits[c_BASE+3] = (w_mover & c_M) == c_M;
            end else begin : g_a_none
                assign w_hits[c_BASE+3] = 1'b0;
            end
        end
    end

    assign w_win          = |w_hits;
    assign w_occ          = r_x | r_o;
    assign w_full         = &w_occ;
    // Out-of-range indices shift the one-hot bit off the top and leave it zero.
    assign w_click_bit    = c_ONE << click_idx;
    assign w_click_ok     = click_valid && (|w_click_bit) && ((w_click_bit & w_occ) == '0);
    assign w_any_rise     = any_click && !r_any_d;
    assign w_restart_rise = restart && !r_restart_d;
    assign w_clear        = w_any_rise && (r_state == S_START || r_state == S_WIN_X ||
                                           r_state == S_WIN_O || r_state == S_TIE);
    assign w_place        = (r_state == S_PLAY) && !w_undo_fire && w_click_ok;

`ifdef UNDO_EN
    logic             r_erase_d, r_undo_valid, r_undo_x;
    logic [IDX_W-1:0] r_undo_idx;
    logic [CELLS-1:0] w_undo_bit;
    assign w_undo_bit  = c_ONE << r_undo_idx;
    assign w_undo_fire = erase && !r_erase_d && (r_state == S_PLAY) && r_undo_valid;
`else
    logic w_unused_erase;
    assign w_unused_erase = erase;
    assign w_undo_fire    = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        if (w_restart_rise) begin
            w_next = S_START;
        end else begin
            case (r_state)
                S_START, S_WIN_X, S_WIN_O, S_TIE: if (w_any_rise) w_next = S_PLAY;
                S_PLAY:  if (w_place) w_next = S_CHECK;
                S_CHECK: begin
                    if (w_win)       w_next = r_turn_x ? S_WIN_X : S_WIN_O;
                    else if (w_full) w_next = S_TIE;
                    else             w_next = S_PLAY;
                end
                default: w_next = S_START;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            r_state     <= S_START;
            r_disp      <= 5'b10000;
            r_x         <= '0;
            r_o         <= '0;
            r_turn_x    <= 1'b1;
            r_score_x   <= '0;
            r_score_o   <= '0;
            r_inc_x     <= 1'b0;
            r_inc_o     <= 1'b0;
            r_any_d     <= 1'b0;
            r_restart_d <= 1'b0;
`ifdef UNDO_EN
            r_erase_d    <= 1'b0;
            r_undo_valid <= 1'b0;
            r_undo_x     <= 1'b0;
            r_undo_idx   <= '0;
`endif
        end else begin
            r_any_d     <= any_click;
            r_restart_d <= restart;
            r_state     <= w_next;
            r_disp      <= f_disp(w_next);
            r_inc_x     <= 1'b0;
            r_inc_o     <= 1'b0;
`ifdef UNDO_EN
            r_erase_d   <= erase;
`endif
            if (w_restart_rise) begin
                r_x       <= '0;
                r_o       <= '0;
                r_turn_x  <= 1'b1;
                r_score_x <= '0;
                r_score_o <= '0;
`ifdef UNDO_EN
                r_undo_valid <= 1'b0;
`endif
            end else if (w_clear) begin
                r_x      <= '0;
                r_o      <= '0;
                r_turn_x <= 1'b1;
`ifdef UNDO_EN
                r_undo_valid <= 1'b0;
            end else if (w_undo_fire) begin
                if (r_undo_x) r_x <= r_x & ~w_undo_bit;
                else          r_o <= r_o & ~w_undo_bit;
                r_turn_x     <= r_undo_x;
                r_undo_valid <= 1'b0;
`endif
            end else if (w_place) begin
                if (r_turn_x) r_x <= r_x | w_click_bit;
                else          r_o <= r_o | w_click_bit;
`ifdef UNDO_EN
                r_undo_valid <= 1'b1;
                r_undo_x     <= r_turn_x;
                r_undo_idx   <= click_idx;
`endif
            end else if (r_state == S_CHECK) begin
                if (w_win) begin
                    if (r_turn_x) begin
                        r_inc_x <= 1'b1;
                        if (r_score_x != '1) r_score_x <= r_score_x + c_SCORE_ONE;
                    end else begin
                        r_inc_o <= 1'b1;
                        if (r_score_o != '1) r_score_o <= r_score_o + c_SCORE_ONE;
                    end
                end else if (!w_full) begin
                    r_turn_x <= !r_turn_x;
                end
            end
        end
    end

    assign x_matrix    = r_x;
    assign o_matrix    = r_o;
    assign turn_x      = r_turn_x;
    assign score_x     = r_score_x;
    assign score_o     = r_score_o;
    assign inc_x_score = r_inc_x;
    assign inc_o_score = r_inc_o;
    assign disp_start  = r_disp[4];
    assign disp_play   = r_disp[3];
    assign disp_win_x  = r_disp[2];
    assign disp_win_o  = r_disp[1];
    assign disp_tie    = r_disp[0];

endmodule
`default_nettype wire

// File: tb/tb_board_game_engine.sv
`default_nettype none
// +-------------------------------------------------------------------------------------+
// | tb_board_game_engine : scoreboard bench; a 3x3 instance and a 4x4/K=3/2-bit-score     |
// | instance share one stimulus stream. Rev 1.0                                           |
// +-------------------------------------------------------------------------------------+
module tb_board_game_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, click_valid, any_click, erase, restart;
    logic [3:0] click_idx;

    logic [8:0]  x3, o3;
    logic [5:0]  sx3, so3;
    logic        turn3, incx3, inco3, ds3, dp3, dwx3, dwo3, dt3;
    logic [15:0] x4, o4;
    logic [1:0]  sx4, so4;
    logic        turn4, incx4, inco4, ds4, dp4, dwx4, dwo4, dt4;

    board_game_engine #(.N(3), .K(3), .SCORE_W(6)) dut3 (
        .clk_100MHz(clk), .reset(reset), .click_valid(click_valid), .click_idx(click_idx),
        .any_click(any_click), .erase(erase), .restart(restart),
        .x_matrix(x3), .o_matrix(o3), .turn_x(turn3), .score_x(sx3), .score_o(so3),
        .inc_x_score(incx3), .inc_o_score(inco3), .disp_start(ds3), .disp_play(dp3),
        .disp_win_x(dwx3), .disp_win_o(dwo3), .disp_tie(dt3)
    );

    board_game_engine #(.N(4), .K(3), .SCORE_W(2)) dut4 (
        .clk_100MHz(clk), .reset(reset), .click_valid(click_valid), .click_idx(click_idx),
        .any_click(any_click), .erase(erase), .restart(restart),
        .x_matrix(x4), .o_matrix(o4), .turn_x(turn4), .score_x(sx4), .score_o(so4),
        .inc_x_score(incx4), .inc_o_score(inco4), .disp_start(ds4), .disp_play(dp4),
        .disp_win_x(dwx4), .disp_win_o(dwo4), .disp_tie(dt4)
    );

    typedef struct packed {
        logic [15:0] xm;
        logic [15:0] om;
        logic        turn;
        logic [4:0]  disp;
        logic [5:0]  sx;
        logic [5:0]  so;
        logic        incx;
        logic        inco;
    } snap_t;

    localparam logic [4:0] D_START = 5'b10000;
    localparam logic [4:0] D_PLAY  = 5'b01000;
    localparam logic [4:0] D_WINX  = 5'b00100;
    localparam logic [4:0] D_WINO  = 5'b00010;
    localparam logic [4:0] D_TIE   = 5'b00001;

    snap_t exp_q[$];
    snap_t got, want;
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic snap_t obs3();
        return {{7'b0, x3}, {7'b0, o3}, turn3, {ds3, dp3, dwx3, dwo3, dt3}, sx3, so3, incx3, inco3};
    endfunction

    function automatic snap_t obs4();
        return {x4, o4, turn4, {ds4, dp4, dwx4, dwo4, dt4}, {4'b0, sx4}, {4'b0, so4}, incx4, inco4};
    endfunction

    function automatic snap_t mk(input logic [15:0] xm, input logic [15:0] om, input logic turn,
                                 input logic [4:0] disp, input logic [5:0] sx, input logic [5:0] so,
                                 input logic incx, input logic inco);
        return {xm, om, turn, disp, sx, so, incx, inco};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; click_valid = 1'b0; click_idx = 4'd0;
        any_click = 1'b0; erase = 1'b0; restart = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic pulse_any();
        any_click = 1'b1; tick();
        any_click = 1'b0; tick();
    endtask

    task automatic place(input logic [3:0] idx);
        click_valid = 1'b1; click_idx = idx; tick();
        click_valid = 1'b0; tick();
    endtask

    task automatic test_reset();
        do_reset();
        exp_q.push_back(mk(16'h0, 16'h0, 1'b1, D_START, 6'd0, 6'd0, 1'b0, 1'b0));
        want = exp_q.pop_front(); got = obs3(); n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL reset_idle: got %h want %h", got, want); end
        pulse_any(); place(4'd0); place(4'd3);
        exp_q.push_back(mk(16'h0001, 16'h0008, 1'b1, D_PLAY, 6'd0, 6'd0, 1'b0, 1'b0));
        want = exp_q.pop_front(); got = obs3(); n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL midgame: got %h want %h", got, want); end
        reset = 1'b0;
        exp_q.push_back(mk(16'h0, 16'h0, 1'b1, D_START, 6'd0, 6'd0, 1'b0, 1'b0));
        #1;
        want = exp_q.pop_front(); got = obs3(); n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL async_reset: got %h want %h", got, want); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_win_x();
        pulse_any(); place(4'd0);
        exp_q.push_back(mk(16'h0001, 16'h0, 1'b0, D_PLAY, 6'd0, 6'd0, 1'b0, 1'b0));
        want = exp_q.pop_front(); got = obs3(); n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL after_x0: got %h want %h", got, want); end
        place(4'd3); place(4'd1); place(4'd4);
        click_valid = 1'b1; click_idx = 4'd2;
        exp_q.push_back(mk(16'h0007, 16'h0018, 1'b1, D_PLAY, 6'd0, 6'd0, 1'b0, 1'b0));
        exp_q.push_back(mk(16'h0007, 16'h0018, 1'b1, D_WINX, 6'd1, 6'd0, 1'b1, 1'b0));
        exp_q.push_back(mk(16'h0007, 16'h0018, 1'b1, D_WINX, 6'd1, 6'd0, 1'b0, 1'b0));
        tick(); click_valid = 1'b0;
        want = exp_q.pop_front(); got = obs3(); n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL check_cycle: got %h want %h", got, want); end
        tick();
        want = exp_q.pop_front(); got = obs3(); n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL win_x: got %h want %h", got, want); end
        tick();
        want = exp_q.pop_front(); got = obs3(); n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL win_x_pulse_end: got %h want %h", got, want); end
    endtask

    task automatic test_tie();
        pulse_any();
        exp_q.push_back(mk(16'h0, 16'h0, 1'b1, D_PLAY, 6'd1, 6'd0, 1'b0, 1'b0));
        want = exp_q.pop_front(); got = obs3(); n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL new_round_cleared: got %h want %h", got, want); end
        place(4'd4); place(4'd0); place(4'd4);
        exp_q.push_back(mk(16'h0010, 16'h0001, 1'b1, D_PLAY, 6'd1, 6'd0, 1'b0, 1'b0));
        want = exp_q.pop_front(); got = obs3(); n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL occupied_ignored: got %h want %h", got, want); end
        place(4'd9);
        exp_q.push_back(mk(16'h0010, 16'h0001, 1'b1, D_PLAY, 6'd1, 6'd0, 1'b0, 1'b0));
        want = exp_q.pop_front(); got = obs3(); n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL out_of_range_ignored: got %h want %h", got, want); end
        place(4'd1); place(4'd7); place(4'd5); place(4'd3);
        place(4'd6); place(4'd2); place(4'd8);
        exp_q.push_back(mk(16'h0172, 16'h008D, 1'b1, D_TIE, 6'd1, 6'd0, 1'b0, 1'b0));
        want = exp_q.pop_front(); got = obs3(); n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL tie: got %h want %h", got, want); end
    endtask

    task automatic test_antidiag();
        do_reset();
        pulse_any();
        place(4'd0); place(4'd6); place(4'd5); place(4'd9); place(4'd15); place(4'd12);
        exp_q.push_back(mk(16'h8021, 16'h1240, 1'b0, D_WINO, 6'd0, 6'd1, 1'b0, 1'b1));
        want = exp_q.pop_front(); got = obs4(); n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL antidiag_win_o: got %h want %h", got, want); end
        pulse_any();
        place(4'd3); place(4'd0); place(4'd6); place(4'd13); place(4'd8); place(4'd15); place(4'd7);
        exp_q.push_back(mk(16'h01C8, 16'hA001, 1'b0, D_PLAY, 6'd0, 6'd1, 1'b0, 1'b0));
        want = exp_q.pop_front(); got = obs4(); n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL row_wrap_no_win: got %h want %h", got, want); end
    endtask

    task automatic test_saturation();
        logic [5:0] s;
        do_reset();
        for (int r = 1; r <= 5; r++) begin
            s = 6'((r > 3) ? 3 : r);
            pulse_any();
            place(4'd0); place(4'd4); place(4'd1); place(4'd5);
            exp_q.push_back(mk(16'h0007, 16'h0030, 1'b1, D_WINX, s, 6'd0, 1'b1, 1'b0));
            place(4'd2);
            want = exp_q.pop_front(); got = obs4(); n_tests++;
            if (got !== want) begin n_fail++; $display("FAIL sat_round%0d: got %h want %h", r, got, want); end
        end
        restart = 1'b1; tick(); restart = 1'b0; tick();
        exp_q.push_back(mk(16'h0, 16'h0, 1'b1, D_START, 6'd0, 6'd0, 1'b0, 1'b0));
        want = exp_q.pop_front(); got = obs4(); n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL restart_clears: got %h want %h", got, want); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pulse_any();
        click_valid = 1'b1; click_idx = 4'd0; tick();
        click_idx = 4'd1; tick();
        click_valid = 1'b0; tick();
        exp_q.push_back(mk(16'h0001, 16'h0, 1'b0, D_PLAY, 6'd0, 6'd0, 1'b0, 1'b0));
        want = exp_q.pop_front(); got = obs3(); n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL click_in_check_ignored: got %h want %h", got, want); end
        restart = 1'b1; any_click = 1'b1; click_valid = 1'b1; click_idx = 4'd4; tick();
        any_click = 1'b0; click_valid = 1'b0; tick();
        exp_q.push_back(mk(16'h0, 16'h0, 1'b1, D_START, 6'd0, 6'd0, 1'b0, 1'b0));
        want = exp_q.pop_front(); got = obs3(); n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL restart_priority: got %h want %h", got, want); end
        pulse_any(); place(4'd4);
        exp_q.push_back(mk(16'h0010, 16'h0, 1'b0, D_PLAY, 6'd0, 6'd0, 1'b0, 1'b0));
        want = exp_q.pop_front(); got = obs3(); n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL restart_level_once: got %h want %h", got, want); end
        restart = 1'b0; tick();
    endtask

    task automatic test_erase();
        do_reset();
        pulse_any(); place(4'd4); place(4'd0);
        erase = 1'b1; tick(); erase = 1'b0; tick();
`ifdef UNDO_EN
        exp_q.push_back(mk(16'h0010, 16'h0, 1'b0, D_PLAY, 6'd0, 6'd0, 1'b0, 1'b0));
        want = exp_q.pop_front(); got = obs3(); n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL undo_last: got %h want %h", got, want); end
        erase = 1'b1; tick(); erase = 1'b0; tick();
        exp_q.push_back(mk(16'h0010, 16'h0, 1'b0, D_PLAY, 6'd0, 6'd0, 1'b0, 1'b0));
        want = exp_q.pop_front(); got = obs3(); n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL undo_second_ignored: got %h want %h", got, want); end
        place(4'd0); place(4'd8);
        erase = 1'b1; tick(); erase = 1'b0; tick();
        exp_q.push_back(mk(16'h0010, 16'h0001, 1'b1, D_PLAY, 6'd0, 6'd0, 1'b0, 1'b0));
        want = exp_q.pop_front(); got = obs3(); n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL undo_x: got %h want %h", got, want); end
`else
        exp_q.push_back(mk(16'h0010, 16'h0001, 1'b1, D_PLAY, 6'd0, 6'd0, 1'b0, 1'b0));
        want = exp_q.pop_front(); got = obs3(); n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL erase_ignored: got %h want %h", got, want); end
`endif
    endtask

    initial begin
        reset = 1'b0; click_valid = 1'b0; click_idx = 4'd0;
        any_click = 1'b0; erase = 1'b0; restart = 1'b0;
        test_reset();
        test_win_x();
        test_tie();
        test_antidiag();
        test_saturation();
        test_back_to_back();
        test_erase();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
